// File: rtl/bnn_seq_classifier_pkg.sv
// Shared types and width helpers for the time-multiplexed BNN classifier.
package bnn_seq_classifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HID  = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Score width: popcount of up to wm bits plus a sign, or the bias, whichever is wider, plus the carry bit.
  function automatic int score_width(input int wm, input int bias_w);
    return max_int($clog2(wm + 1) + 1, bias_w) + 1;
  endfunction

endpackage

// File: rtl/bnn_seq_classifier_xnor_popcount.sv
// One binary neuron: masked XNOR-popcount plus signed bias, and its sign activation.
module bnn_xnor_popcount #(
  parameter int WIDTH  = 8,
  parameter int BIAS_W = 5,
  parameter int SW     = 6
) (
  input  logic [WIDTH-1:0]         x,
  input  logic [WIDTH-1:0]         w,
  input  logic [WIDTH-1:0]         mask,
  input  logic signed [BIAS_W-1:0] bias,
  output logic signed [SW-1:0]     sum,
  output logic                     act
);

  logic [WIDTH-1:0] match;
  logic [SW-1:0]    cnt;

  always_comb begin
    match = ~(x ^ w) & mask;
    cnt   = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + SW'(match[i]);
    sum = $signed(cnt + {{(SW - BIAS_W){bias[BIAS_W-1]}}, bias});
    act = ~sum[SW-1];
  end

endmodule

// File: rtl/bnn_seq_classifier.sv
// Time-multiplexed BNN classifier: one neuron per enabled cycle through a shared XNOR-popcount datapath.
module bnn_seq_classifier
  import bnn_seq_classifier_pkg::*;
#(
  parameter int N_IN        = 8,
  parameter int N_HID       = 4,
  parameter int N_OUT       = 2,
  parameter int BIAS_W      = 5,
  parameter int ALERT_CLASS = 1,
  localparam int NR = N_HID + N_OUT,
  localparam int AW = $clog2(NR),
  localparam int WM = max_int(N_IN, N_HID),
  localparam int SW = score_width(WM, BIAS_W),
  localparam int CW = $clog2(N_OUT),
  localparam int IW = max_int(1, $clog2(max_int(N_HID, N_OUT)))
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     cfg_we,
  input  logic [AW-1:0]            cfg_addr,
  input  logic [WM-1:0]            cfg_wdata,
  input  logic signed [BIAS_W-1:0] cfg_bias,
  output logic                     cfg_err,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_IN-1:0]          in_bits,
  input  logic                     alert_force,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_class,
  output logic signed [SW-1:0]     out_score,
  output logic [N_HID-1:0]         out_hidden,
  output logic                     out_alert
);

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [N_IN-1:0]         x_q;
  logic [N_HID-1:0]        hid_q;
  logic signed [SW-1:0]    best_score_q, new_score;
  logic [CW-1:0]           best_class_q, new_class;
  logic [WM-1:0]           w_q [NR];
  logic signed [BIAS_W-1:0] b_q [NR];

  logic                    accept, cfg_ok, take_new;
  logic [AW-1:0]           row;
  logic [WM-1:0]           x_op, mask_op;
  logic signed [SW-1:0]    sum;
  logic                    act;

  assign in_ready  = (state_q == ST_IDLE) && ena;
  assign out_valid = (state_q == ST_DONE);
  assign out_alert = (out_valid && (out_class == CW'(ALERT_CLASS))) || alert_force;
  assign cfg_ok    = cfg_we && (state_q == ST_IDLE) && (int'(cfg_addr) < NR);

  // Operand mux: hidden layer reads the latched features, output layer reads the hidden vector.
  always_comb begin
    row     = AW'(idx_q);
    x_op    = WM'(x_q);
    mask_op = WM'({N_IN{1'b1}});
    if (state_q == ST_OUT) begin
      row     = AW'(N_HID) + AW'(idx_q);
      x_op    = WM'(hid_q);
      mask_op = WM'({N_HID{1'b1}});
    end
  end

  bnn_xnor_popcount #(.WIDTH(WM), .BIAS_W(BIAS_W), .SW(SW)) u_neuron (
    .x    (x_op),
    .w    (w_q[row]),
    .mask (mask_op),
    .bias (b_q[row]),
    .sum  (sum),
    .act  (act)
  );

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    accept    = 1'b0;
    take_new  = (idx_q == '0) || (sum > best_score_q);
    new_score = take_new ? sum : best_score_q;
    new_class = take_new ? CW'(idx_q) : best_class_q;
    unique case (state_q)
      ST_IDLE: if (in_valid && in_ready) begin
        accept  = 1'b1;
        state_d = ST_HID;
        idx_d   = '0;
      end
      ST_HID: begin
        if (idx_q == IW'(N_HID - 1)) begin
          state_d = ST_OUT;
          idx_d   = '0;
        end else idx_d = idx_q + 1'b1;
      end
      ST_OUT: begin
        if (idx_q == IW'(N_OUT - 1)) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else idx_d = idx_q + 1'b1;
      end
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the weight array is reset like any other state because a reset must clear loaded weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      x_q          <= '0;
      hid_q        <= '0;
      best_score_q <= '0;
      best_class_q <= '0;
      out_hidden   <= '0;
      out_class    <= '0;
      out_score    <= '0;
      cfg_err      <= 1'b0;
      for (int r = 0; r < NR; r++) begin
        w_q[r] <= '0;
        b_q[r] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      cfg_err <= ena && cfg_we && !cfg_ok;
      if (ena) begin
        state_q <= state_d;
        idx_q   <= idx_d;
        if (cfg_ok) begin
          w_q[cfg_addr] <= cfg_wdata;
          b_q[cfg_addr] <= cfg_bias;
        end
        if (accept) x_q <= in_bits;
        if (state_q == ST_HID) hid_q[idx_q] <= act;
        if (state_q == ST_OUT) begin
          best_score_q <= new_score;
          best_class_q <= new_class;
          // Published outputs change only on DONE entry and hold through IDLE.
          if (state_d == ST_DONE) begin
            out_hidden <= hid_q;
            out_class  <= new_class;
            out_score  <= new_score;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_seq_classifier.sv
// Randomised self-checking bench for bnn_seq_classifier against a plain-arithmetic neuron model.
module tb_bnn_seq_classifier;

  logic              clk = 1'b0;
  logic              rst_n, ena, cfg_we, cfg_err;
  logic [2:0]        cfg_addr;
  logic [7:0]        cfg_wdata;
  logic signed [4:0] cfg_bias;
  logic              in_valid, in_ready, alert_force;
  logic [7:0]        in_bits;
  logic              out_valid, out_ready, out_alert;
  logic [0:0]        out_class;
  logic signed [5:0] out_score;
  logic [3:0]        out_hidden;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mw [6];
  int         mb [6];

  bnn_seq_classifier dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_bias(cfg_bias), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .alert_force(alert_force),
    .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_score(out_score),
    .out_hidden(out_hidden), .out_alert(out_alert)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: hidden neuron n fires when (#agreeing bits + bias) >= 0; argmax keeps the first maximum.
  function automatic void model(input logic [7:0] x, output logic [3:0] h, output int cls, output int score);
    int s;
    int best;
    best = 0;
    cls  = 0;
    for (int n = 0; n < 4; n++) begin
      s = mb[n];
      for (int j = 0; j < 8; j++) if (x[j] == mw[n][j]) s++;
      h[n] = (s >= 0);
    end
    for (int o = 0; o < 2; o++) begin
      s = mb[4 + o];
      for (int j = 0; j < 4; j++) if (h[j] == mw[4 + o][j]) s++;
      if (o == 0 || s > best) begin
        best = s;
        cls  = o;
      end
    end
    score = best;
  endfunction

  task automatic clear_model();
    for (int r = 0; r < 6; r++) begin
      mw[r] = 8'h00;
      mb[r] = 0;
    end
  endtask

  task automatic cfg_write(input int a, input logic [7:0] w, input int b);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_wdata = w; cfg_bias = 5'(b);
    step();
    cfg_we = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      $display("FAIL cfg_write_err row=%0d got=%b want=0", a, cfg_err); n_bad++;
    end
    mw[a] = w;
    mb[a] = b;
  endtask

  task automatic randomize_weights();
    for (int r = 0; r < 6; r++) cfg_write(r, 8'($urandom), int'($urandom_range(0, 31)) - 16);
  endtask

  task automatic wait_ready(input string tag);
    int w = 0;
    while (in_ready !== 1'b1 && w < 20) begin step(); w++; end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      $display("FAIL %s_ready_timeout got=%b want=1", tag, in_ready); n_bad++;
    end
  endtask

  task automatic wait_valid(input bit toggle_ena, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      if (toggle_ena) ena = ~ena;
      step();
      n++;
    end
    ena = 1'b1;
  endtask

  task automatic check_result(input string tag, input logic [3:0] eh, input int ec, input int es);
    n_cmp += 5;
    if (out_valid !== 1'b1) begin
      $display("FAIL %s_valid got=%b want=1", tag, out_valid); n_bad++;
    end
    if (out_hidden !== eh) begin
      $display("FAIL %s_hidden got=%h want=%h", tag, out_hidden, eh); n_bad++;
    end
    if (out_class !== 1'(ec)) begin
      $display("FAIL %s_class got=%0d want=%0d", tag, out_class, ec); n_bad++;
    end
    if (out_score !== 6'(es)) begin
      $display("FAIL %s_score got=%0d want=%0d", tag, out_score, es); n_bad++;
    end
    if (out_alert !== ((ec == 1) || alert_force)) begin
      $display("FAIL %s_alert got=%b want=%b", tag, out_alert, (ec == 1) || alert_force); n_bad++;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL %s_release valid=%b ready=%b want 0/1", tag, out_valid, in_ready); n_bad++;
    end
  endtask

  task automatic run_vector(input logic [7:0] x, input bit toggle_ena, input string tag);
    logic [3:0] eh;
    int ec, es, n;
    model(x, eh, ec, es);
    wait_ready(tag);
    in_valid = 1'b1; in_bits = x;
    step();
    in_valid = 1'b0; in_bits = 8'($urandom);
    wait_valid(toggle_ena, n);
    if (!toggle_ena) begin
      n_cmp++;
      if (n != 6) begin
        $display("FAIL %s_latency got=%0d want=6", tag, n); n_bad++;
      end
    end
    alert_force = 1'($urandom);
    #1;
    check_result(tag, eh, ec, es);
    alert_force = 1'b0;
    consume(tag);
  endtask

  task automatic test_reset();
    n_cmp += 4;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || cfg_err !== 1'b0) begin
      $display("FAIL reset_ctrl ready=%b valid=%b err=%b want 1/0/0", in_ready, out_valid, cfg_err); n_bad++;
    end
    if (out_class !== 1'b0 || out_score !== 6'sd0 || out_hidden !== 4'h0) begin
      $display("FAIL reset_outs class=%0d score=%0d hidden=%h want 0/0/0", out_class, out_score, out_hidden); n_bad++;
    end
    if (out_alert !== 1'b0) begin
      $display("FAIL reset_alert got=%b want=0", out_alert); n_bad++;
    end
    alert_force = 1'b1;
    #1;
    if (out_alert !== 1'b1) begin
      $display("FAIL reset_alert_force got=%b want=1", out_alert); n_bad++;
    end
    for (int c = 0; c < 20; c++) begin
      alert_force = 1'($urandom);
      step();
      n_cmp++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_alert !== alert_force) begin
        $display("FAIL idle_hold c=%0d ready=%b valid=%b alert=%b want 1/0/%b", c, in_ready, out_valid, out_alert, alert_force);
        n_bad++;
      end
    end
    alert_force = 1'b0;
  endtask

  task automatic test_directed();
    for (int r = 0; r < 4; r++) cfg_write(r, 8'hFF, -4);
    cfg_write(4, 8'h00, 0);
    cfg_write(5, 8'h0F, 0);
    run_vector(8'hFF, 1'b0, "dir_ff");
    run_vector(8'h00, 1'b0, "dir_00");
  endtask

  task automatic test_tie();
    cfg_write(4, 8'h0F, 0);
    cfg_write(5, 8'h0F, 0);
    run_vector(8'hFF, 1'b0, "tie");
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      randomize_weights();
      run_vector(8'($urandom), 1'b0, "rand");
    end
  endtask

  task automatic test_cfg_and_accept();
    logic [3:0] eh;
    int ec, es, n;
    logic [7:0] x;
    wait_ready("simul");
    x = 8'($urandom);
    mw[5] = 8'($urandom); mb[5] = int'($urandom_range(0, 31)) - 16;
    model(x, eh, ec, es);
    cfg_we = 1'b1; cfg_addr = 3'd5; cfg_wdata = mw[5]; cfg_bias = 5'(mb[5]);
    in_valid = 1'b1; in_bits = x;
    step();
    cfg_we = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      $display("FAIL simul_err got=%b want=0", cfg_err); n_bad++;
    end
    wait_valid(1'b0, n);
    check_result("simul", eh, ec, es);
    consume("simul");
  endtask

  task automatic test_backpressure();
    logic [3:0] eh;
    int ec, es, n;
    logic [7:0] x;
    randomize_weights();
    x = 8'($urandom);
    model(x, eh, ec, es);
    wait_ready("bp");
    in_valid = 1'b1; in_bits = x;
    step();
    in_valid = 1'b0;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = ~mw[0]; cfg_bias = 5'(mb[0] ^ 5);
    step();
    cfg_we = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      $display("FAIL busy_cfg_err got=%b want=1", cfg_err); n_bad++;
    end
    wait_valid(1'b0, n);
    for (int c = 0; c < 10; c++) begin
      check_result("bp_hold", eh, ec, es);
      n_cmp++;
      if (in_ready !== 1'b0) begin
        $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready); n_bad++;
      end
      step();
    end
    consume("bp");
    cfg_we = 1'b1; cfg_addr = 3'd6; cfg_wdata = 8'hA5; cfg_bias = 5'sd3;
    step();
    cfg_we = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      $display("FAIL addr6_err got=%b want=1", cfg_err); n_bad++;
    end
    step();
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      $display("FAIL err_pulse got=%b want=0", cfg_err); n_bad++;
    end
    run_vector(x, 1'b0, "bp_unchanged");
  endtask

  task automatic test_ena_toggle();
    logic [7:0] x;
    randomize_weights();
    for (int t = 0; t < 3; t++) begin
      x = 8'($urandom);
      run_vector(x, 1'b1, "ena_toggle");
      run_vector(x, 1'b0, "ena_ref");
    end
  endtask

  task automatic test_reset_mid();
    randomize_weights();
    wait_ready("rst_mid");
    in_valid = 1'b1; in_bits = 8'($urandom);
    step();
    in_valid = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    #2;
    n_cmp += 2;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || cfg_err !== 1'b0) begin
      $display("FAIL rst_mid_ctrl valid=%b ready=%b err=%b want 0/1/0", out_valid, in_ready, cfg_err); n_bad++;
    end
    if (out_class !== 1'b0 || out_score !== 6'sd0 || out_hidden !== 4'h0) begin
      $display("FAIL rst_mid_outs class=%0d score=%0d hidden=%h want 0", out_class, out_score, out_hidden); n_bad++;
    end
    step();
    rst_n = 1'b1;
    clear_model();
    run_vector(8'($urandom), 1'b0, "rst_zero_w");
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_bias = '0;
    in_valid = 1'b0; in_bits = '0; alert_force = 1'b0; out_ready = 1'b0;
    clear_model();
    #12;
    test_reset();
    rst_n = 1'b1;
    step();
    test_directed();
    test_tie();
    test_random();
    test_cfg_and_accept();
    test_backpressure();
    test_ena_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
